pl_adc: RTL and testbench



---
 rtl/pl_adc_pkg.sv | 25 ++
 rtl/pl_adc_edge_det.sv | 23 ++
 rtl/pl_adc.sv | 97 +++++++++
 tb/tb_pl_adc.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pl_adc_pkg.sv
// pl_adc_pkg: shared constants for the pl_adc capture/averaging front end.
// Holds the default parameter values, the FSM state encoding and a small
// width helper used to size the down-counter.
package pl_adc_pkg;

   // Default configuration
   localparam int DEF_DATA_W     = 14;
   localparam int DEF_SETTLE_CYC = 2;
   localparam int DEF_AVG_LOG2   = 2;

   // FSM state encoding, kept as plain constants for legacy tools
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETTLE = 2'd1;
   localparam state_t ST_ACQ    = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   // Bits needed to hold values 0..max_val, never less than one bit
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pl_adc_edge_det.sv
// pl_adc_edge_det: registers the work request and flags its low-to-high
// transition. The flag is combinational so the FSM acts on the same edge
// that first sees the request high.
module pl_adc_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic w_q;

   // Previous value of the request, used as the reference for the edge
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registered state always uses non-blocking assignment so every
      // flop samples the pre-edge values and simulation matches hardware.
      if (!rst_n) w_q <= 1'b0;
      else        w_q <= din;
   end

   assign rise = din & ~w_q;

endmodule

// File: rtl/pl_adc.sv
// pl_adc: capture and averaging front end for a parallel CMOS-output ADC.
// A rising edge on i_ADC_Work discards SETTLE_CYC cycles, then sums
// 2^AVG_LOG2 registered samples and publishes the truncated mean together
// with a one-cycle done pulse.
// Build option: define PL_ADC_AVG_EN to enable averaging; without it
// AVG_LOG2 is forced to 0 and a single sample is returned.
module pl_adc
   import pl_adc_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
   input  logic              i_CMOS_Clk,
   input  logic              i_Rst_n,
   input  logic [DATA_W-1:0] i_CMOS_Data,
   input  logic              i_ADC_Work,
   output logic [DATA_W-1:0] o_CMOS_Data,
   output logic              o_ADC_Done
);

`ifdef PL_ADC_AVG_EN
   localparam bit AVG_ON = 1'b1;
`else
   localparam bit AVG_ON = 1'b0;
`endif

   // Effective averaging exponent; the accumulator is exactly wide enough
   // for 2^AVG_EFF full-scale samples, so the sum cannot wrap.
   localparam int AVG_EFF = AVG_ON ? AVG_LOG2 : 0;
   localparam int N_SAMP  = 1 << AVG_EFF;
   localparam int ACC_W   = DATA_W + AVG_EFF;
   localparam int CNT_MAX = (SETTLE_CYC > N_SAMP) ? SETTLE_CYC - 1 : N_SAMP - 1;
   localparam int CNT_W   = cnt_width(CNT_MAX);

   logic [DATA_W-1:0] d_q;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   state_t            state;
   logic              trig;

   pl_adc_edge_det u_edge_det (
      .clk   (i_CMOS_Clk),
      .rst_n (i_Rst_n),
      .din   (i_ADC_Work),
      .rise  (trig)
   );

   // Input register: every sample used by the accumulator is one edge old
   always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) d_q <= '0;
      else          d_q <= i_CMOS_Data;
   end

   // Conversion FSM with shared down-counter, accumulator and result register
   always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         acc         <= '0;
         o_CMOS_Data <= '0;
         o_ADC_Done  <= 1'b0;
      end else begin
         o_ADC_Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trig) begin
                  cnt   <= CNT_W'(SETTLE_CYC - 1);
                  acc   <= '0;
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == '0) begin
                  cnt   <= CNT_W'(N_SAMP - 1);
                  state <= ST_ACQ;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_ACQ: begin
               acc <= acc + ACC_W'(d_q);
               if (cnt == '0) state <= ST_DONE;
               else           cnt   <= cnt - 1'b1;
            end
            ST_DONE: begin
               // Truncating mean; a trigger arriving now is deliberately dropped
               o_CMOS_Data <= DATA_W'(acc >> AVG_EFF);
               o_ADC_Done  <= 1'b1;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pl_adc.sv
// tb_pl_adc: self-checking bench for pl_adc. Expected results come from the
// arithmetic definition of the conversion: the mean (integer division) of
// the raw inputs present at the sample edges, published SETTLE+N+1 edges
// after the triggering edge.
module tb_pl_adc;

   localparam int SETTLE = 2;
`ifdef PL_ADC_AVG_EN
   localparam int AVG = 2;
`else
   localparam int AVG = 0;
`endif
   localparam int N      = 1 << AVG;
   localparam int DONE_E = SETTLE + N + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] din;
   logic        work;
   logic [13:0] dout;
   logic        done;

   int n_vec = 0;
   int n_err = 0;
   logic [13:0] prev_res = '0;

   pl_adc #(.DATA_W(14), .SETTLE_CYC(SETTLE), .AVG_LOG2(2)) dut (
      .i_CMOS_Clk  (clk),
      .i_Rst_n     (rst_n),
      .i_CMOS_Data (din),
      .i_ADC_Work  (work),
      .o_CMOS_Data (dout),
      .o_ADC_Done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One conversion. mode 0: single-cycle request; 1: request held for 20
   // edges; 2: extra rising edges in ACQ and on the DONE edge.
   task automatic run_conv(input logic [13:0] v0, input logic [13:0] v1,
                           input logic [13:0] v2, input logic [13:0] v3,
                           input int mode, input string tag);
      logic [13:0] stim [32];
      logic [13:0] samp [4];
      int sum, exp_res, last, pulses;
      logic w;
      samp = '{v0, v1, v2, v3};
      for (int k = 0; k < 32; k++) stim[k] = 14'($urandom);
      sum = 0;
      for (int i = 0; i < N; i++) begin
         stim[SETTLE + i] = samp[i];
         sum += int'(samp[i]);
      end
      exp_res = sum / N;
      last    = (mode == 1) ? 21 : DONE_E + 2;
      pulses  = 0;
      for (int k = 0; k <= last; k++) begin
         case (mode)
            1:       w = (k < 20);
            2:       w = (k == 0) || (k == 3) || (k == DONE_E);
            default: w = (k == 0);
         endcase
         din  = stim[k];
         work = w;
         @(posedge clk); #1;
         if (done) pulses++;
         if (k < DONE_E) begin
            check({tag, " done low"}, 32'(done), 32'd0);
            check({tag, " held"}, 32'(dout), 32'(prev_res));
         end else if (k == DONE_E) begin
            check({tag, " done pulse"}, 32'(done), 32'd1);
            check({tag, " result"}, 32'(dout), 32'(exp_res));
         end else begin
            check({tag, " done cleared"}, 32'(done), 32'd0);
            check({tag, " result held"}, 32'(dout), 32'(exp_res));
         end
      end
      check({tag, " pulse count"}, 32'(pulses), 32'd1);
      prev_res = 14'(exp_res);
      work = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      din   = '0;
      work  = 1'b0;
      #12;
      check("reset data", 32'(dout), 32'd0);
      check("reset done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed conversions
      run_conv(14'h1234, 14'h1234, 14'h1234, 14'h1234, 0, "const1234");
      run_conv(14'd10, 14'd20, 14'd30, 14'd40, 0, "ramp");
      run_conv(14'd1, 14'd2, 14'd2, 14'd2, 0, "trunc");
      run_conv(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 0, "fullscale");
      run_conv(14'h0ABC, 14'h0ABC, 14'h0ABC, 14'h0ABC, 0, "const0abc");
      run_conv(14'h0111, 14'h2222, 14'h0333, 14'h1444, 1, "hold20");
      run_conv(14'h0F00, 14'h00F0, 14'h000F, 14'h3000, 2, "extra_edges");

      // Randomised conversions
      for (int r = 0; r < 10; r++)
         run_conv(14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom), 0, "random");

      // Reset mid-conversion, then a fresh conversion
      din  = 14'h2AAA;
      work = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(posedge clk); #1;
         work = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("midrst data", 32'(dout), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check("midrst no pulse", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      prev_res = '0;
      for (int k = 0; k < DONE_E + 2; k++) begin
         @(posedge clk); #1;
         check("post-rst quiet", 32'(done), 32'd0);
      end
      run_conv(14'h0555, 14'h0666, 14'h0777, 14'h0888, 0, "after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
